// File: rtl/uart_fifo_interfaz.sv
// Full-duplex UART with parametrised word, parity and stop bits,
// a control/status register and an RX FIFO behind a small register port.
module uart_fifo_interfaz #(
   parameter int palabra    = 8,
   parameter int prescale   = 10417,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_i,
   input  logic               rd_i,
   input  logic               reg_sel_i,
   input  logic               addr_i,
   input  logic [palabra-1:0] entrada_i,
   output logic [palabra-1:0] data,
   output logic [palabra-1:0] ctrl,
   input  logic               rxd,
   output logic               txd
);

   localparam int CW = $clog2(prescale);
   localparam int BW = $clog2(palabra);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CLAST = CW'(prescale - 1);
   localparam logic [CW-1:0] CHALF = CW'(prescale / 2 - 1);
   localparam logic [BW-1:0] BLAST = BW'(palabra - 1);
   localparam logic [AW:0]   FCAP  = (AW+1)'(FIFO_DEPTH);
   localparam logic          SLAST = 1'(STOP_BITS - 1);
   localparam logic          PODD  = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP
   } st_t;

   st_t              tx_st_q, tx_st_d;
   st_t              rx_st_q, rx_st_d;
   logic [CW-1:0]    tx_cnt_q, tx_cnt_d;
   logic [CW-1:0]    rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]    tx_bit_q, tx_bit_d;
   logic [BW-1:0]    rx_bit_q, rx_bit_d;
   logic             tx_stp_q, tx_stp_d;
   logic [palabra-1:0] tx_hold_q, tx_hold_d;
   logic [palabra-1:0] rx_sh_q, rx_sh_d;
   logic             txd_q, txd_d;
   logic             send_q, send_d;
   logic             ovr_q, ovr_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             s1_q, s2_q, s3_q;
   logic [palabra-1:0] mem_q [FIFO_DEPTH];
   logic [palabra-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]      fcnt_q, fcnt_d;

   logic wr_ctrl, wr_tx, pop, tx_busy, tx_last, rx_last;
   logic push, perr_set, ferr_set, full, wr_en, ovr_set;

   assign wr_ctrl = wr_i & ~reg_sel_i;
   assign wr_tx   = wr_i & reg_sel_i & ~addr_i;
   assign pop     = rd_i & reg_sel_i & addr_i & (fcnt_q != '0);
   assign tx_busy = (tx_st_q != S_IDLE);
   assign tx_last = (tx_cnt_q == CLAST);
   assign rx_last = (rx_cnt_q == CLAST);
   assign full    = (fcnt_q == FCAP);
   assign txd     = txd_q;

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_cnt_d  = tx_cnt_q;
      tx_bit_d  = tx_bit_q;
      tx_stp_d  = tx_stp_q;
      tx_hold_d = tx_hold_q;
      txd_d     = txd_q;
      send_d    = send_q;
      if (wr_tx && !tx_busy)
         tx_hold_d = entrada_i;
      if (tx_busy)
         tx_cnt_d = tx_last ? '0 : tx_cnt_q + 1'b1;
      unique case (tx_st_q)
         S_IDLE: begin
            if (wr_ctrl && entrada_i[0]) begin
               tx_st_d  = S_START;
               tx_cnt_d = '0;
               txd_d    = 1'b0;
               send_d   = 1'b1;
            end
         end
         S_START: begin
            if (tx_last) begin
               tx_st_d  = S_DATA;
               tx_bit_d = '0;
               txd_d    = tx_hold_q[0];
            end
         end
         S_DATA: begin
            if (tx_last) begin
               if (tx_bit_q == BLAST) begin
                  if (PARITY != 0) begin
                     tx_st_d = S_PAR;
                     txd_d   = (^tx_hold_q) ^ PODD;
                  end else begin
                     tx_st_d  = S_STOP;
                     tx_stp_d = 1'b0;
                     txd_d    = 1'b1;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
                  txd_d    = tx_hold_q[tx_bit_d];
               end
            end
         end
         S_PAR: begin
            if (tx_last) begin
               tx_st_d  = S_STOP;
               tx_stp_d = 1'b0;
               txd_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (tx_last) begin
               if (tx_stp_q == SLAST) begin
                  tx_st_d = S_IDLE;
                  send_d  = 1'b0;
               end else begin
                  tx_stp_d = 1'b1;
               end
            end
         end
         default: tx_st_d = S_IDLE;
      endcase
   end

   // s3_q holds the previous synchronised level for start-edge detection
   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      push     = 1'b0;
      perr_set = 1'b0;
      ferr_set = 1'b0;
      if (rx_st_q != S_IDLE)
         rx_cnt_d = rx_last ? '0 : rx_cnt_q + 1'b1;
      unique case (rx_st_q)
         S_IDLE: begin
            if (s3_q && !s2_q) begin
               rx_st_d  = S_START;
               rx_cnt_d = '0;
            end
         end
         S_START: begin
            if (rx_cnt_q == CHALF) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_st_d  = s2_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (rx_last) begin
               rx_sh_d = {s2_q, rx_sh_q[palabra-1:1]};
               if (rx_bit_q == BLAST)
                  rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
               else
                  rx_bit_d = rx_bit_q + 1'b1;
            end
         end
         S_PAR: begin
            if (rx_last) begin
               perr_set = ((^rx_sh_q) ^ s2_q) != PODD;
               rx_st_d  = S_STOP;
            end
         end
         S_STOP: begin
            if (rx_last) begin
               push     = 1'b1;
               ferr_set = ~s2_q;
               rx_st_d  = S_IDLE;
            end
         end
         default: rx_st_d = S_IDLE;
      endcase
   end

   // a push into a full FIFO still lands when a pop frees the head slot
   always_comb begin
      mem_d   = mem_q;
      wr_en   = push & (~full | pop);
      ovr_set = push & full & ~pop;
      wp_d    = wp_q;
      rp_d    = rp_q;
      fcnt_d  = fcnt_q;
      if (wr_en) begin
         mem_d[wp_q] = rx_sh_q;
         wp_d        = wp_q + 1'b1;
      end
      if (pop)
         rp_d = rp_q + 1'b1;
      if (wr_en && !pop)
         fcnt_d = fcnt_q + 1'b1;
      else if (pop && !wr_en)
         fcnt_d = fcnt_q - 1'b1;
      ovr_d  = ovr_q;
      perr_d = perr_q;
      ferr_d = ferr_q;
      if (wr_ctrl && entrada_i[2]) ovr_d  = 1'b0;
      if (wr_ctrl && entrada_i[3]) perr_d = 1'b0;
      if (wr_ctrl && entrada_i[4]) ferr_d = 1'b0;
      if (ovr_set)  ovr_d  = 1'b1;
      if (perr_set) perr_d = 1'b1;
      if (ferr_set) ferr_d = 1'b1;
   end

   always_comb begin
      ctrl      = '0;
      ctrl[6:0] = {tx_busy, full, ferr_q, perr_q, ovr_q,
                   (fcnt_q != '0), send_q};
      data      = (fcnt_q == '0) ? '0 : mem_q[rp_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_st_q   <= S_IDLE;
         rx_st_q   <= S_IDLE;
         tx_cnt_q  <= '0;
         rx_cnt_q  <= '0;
         tx_bit_q  <= '0;
         rx_bit_q  <= '0;
         tx_stp_q  <= 1'b0;
         tx_hold_q <= '0;
         rx_sh_q   <= '0;
         txd_q     <= 1'b1;
         send_q    <= 1'b0;
         ovr_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         s1_q      <= 1'b1;
         s2_q      <= 1'b1;
         s3_q      <= 1'b1;
         wp_q      <= '0;
         rp_q      <= '0;
         fcnt_q    <= '0;
      end else begin
         tx_st_q   <= tx_st_d;
         rx_st_q   <= rx_st_d;
         tx_cnt_q  <= tx_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         tx_bit_q  <= tx_bit_d;
         rx_bit_q  <= rx_bit_d;
         tx_stp_q  <= tx_stp_d;
         tx_hold_q <= tx_hold_d;
         rx_sh_q   <= rx_sh_d;
         txd_q     <= txd_d;
         send_q    <= send_d;
         ovr_q     <= ovr_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         s1_q      <= rxd;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         fcnt_q    <= fcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_uart_fifo_interfaz.sv
// Directed bench for uart_fifo_interfaz: one instance without parity,
// one with even parity; prescale 16, FIFO depth 4.
module tb_uart_fifo_interfaz;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr = 1'b0, rd = 1'b0, sel = 1'b0, adr = 1'b0;
   logic [7:0] din = '0;
   logic       rxd = 1'b1, rxd_p = 1'b1;
   logic [7:0] data, ctrl, data_p, ctrl_p;
   logic       txd, txd_p;
   int         total = 0;
   int         bad = 0;
   logic [9:0] pat;

   always #5 clk = ~clk;

   uart_fifo_interfaz #(
      .palabra(8), .prescale(16), .FIFO_DEPTH(4),
      .PARITY(0), .STOP_BITS(1)
   ) dut (
      .clk(clk), .rst(rst), .wr_i(wr), .rd_i(rd),
      .reg_sel_i(sel), .addr_i(adr), .entrada_i(din),
      .data(data), .ctrl(ctrl), .rxd(rxd), .txd(txd)
   );

   uart_fifo_interfaz #(
      .palabra(8), .prescale(16), .FIFO_DEPTH(4),
      .PARITY(1), .STOP_BITS(1)
   ) dut_p (
      .clk(clk), .rst(rst), .wr_i(wr), .rd_i(rd),
      .reg_sel_i(sel), .addr_i(adr), .entrada_i(din),
      .data(data_p), .ctrl(ctrl_p), .rxd(rxd_p), .txd(txd_p)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wreg(input logic s, input logic a, input logic [7:0] v);
      @(negedge clk);
      wr = 1'b1; sel = s; adr = a; din = v;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      rd = 1'b1; sel = 1'b1; adr = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic rx_bits(input logic [15:0] b, input int n, input bit p);
      for (int i = 0; i < n; i++) begin
         if (p) rxd_p = b[i];
         else   rxd   = b[i];
         tick(16);
      end
      rxd = 1'b1;
      rxd_p = 1'b1;
      tick(4);
   endtask

   task automatic frame8(input logic [7:0] d);
      rx_bits({6'h0, 1'b1, d, 1'b0}, 10, 1'b0);
   endtask

   initial begin
      tick(3);
      chk("rst_txd", txd, 1);
      chk("rst_ctrl", ctrl, 8'h00);
      chk("rst_data", data, 8'h00);
      rst = 1'b0;
      tick(2);

      // TX of 0xAA
      pat = 10'b1101010100;
      wreg(1'b1, 1'b0, 8'hAA);
      wreg(1'b0, 1'b0, 8'h01);
      chk("tx_busy_on", ctrl[6:0] & 7'h41, 7'h41);
      for (int k = 0; k < 160; k++) begin
         if (k % 16 == 0 || k % 16 == 15)
            chk($sformatf("txd_k%0d", k), txd, pat[k/16]);
         if (k == 159)
            chk("tx_busy_159", ctrl[6:0] & 7'h41, 7'h41);
         tick(1);
      end
      chk("tx_done_ctrl", ctrl[6:0] & 7'h41, 7'h00);
      chk("tx_done_txd", txd, 1);
      tick(5);

      // RX 0xAD then pop
      frame8(8'hAD);
      chk("rx_data", data, 8'hAD);
      chk("rx_ne", ctrl[1], 1);
      pop();
      chk("rx_pop_ne", ctrl[1], 0);
      chk("rx_pop_data", data, 8'h00);
      pop();
      chk("pop_empty", ctrl, 8'h00);

      // overrun on fifth frame
      for (int i = 1; i <= 5; i++) frame8(8'(i));
      chk("ovr_full", ctrl[5], 1);
      chk("ovr_flag", ctrl[2], 1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovr_pop%0d", i), data, 32'(i));
         pop();
      end
      chk("ovr_drained", ctrl[1], 0);
      chk("ovr_nfull", ctrl[5], 0);
      wreg(1'b0, 1'b0, 8'h04);
      chk("ovr_clr", ctrl, 8'h00);

      // even parity instance
      rx_bits({5'h0, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 1'b1);
      chk("par_data", data_p, 8'h03);
      chk("par_err", ctrl_p[3], 1);
      chk("par_nofe", ctrl_p[4], 0);
      rx_bits({5'h0, 1'b0, 1'b1, 8'h07, 1'b0}, 11, 1'b1);
      tick(16);
      chk("fe_set", ctrl_p[4], 1);
      chk("fe_head", data_p, 8'h03);
      wreg(1'b0, 1'b0, 8'h08);
      chk("pe_clr", ctrl_p[3], 0);
      chk("fe_kept", ctrl_p[4], 1);
      pop();
      chk("fe_data", data_p, 8'h07);
      pop();
      wreg(1'b0, 1'b0, 8'h10);
      chk("fe_clr", ctrl_p, 8'h00);

      // short glitch is rejected
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(40);
      chk("glitch_ne", ctrl[1], 0);
      chk("glitch_data", data, 8'h00);
      frame8(8'h5A);
      chk("glitch_after", data, 8'h5A);

      // reset mid-TX and mid-RX
      wreg(1'b1, 1'b0, 8'h3C);
      wreg(1'b0, 1'b0, 8'h01);
      rxd = 1'b0;
      tick(70);
      chk("mid_busy", ctrl[6], 1);
      rst = 1'b1;
      rxd = 1'b1;
      tick(1);
      chk("mrst_txd", txd, 1);
      chk("mrst_txd_p", txd_p, 1);
      chk("mrst_ctrl", ctrl, 8'h00);
      chk("mrst_data", data, 8'h00);
      rst = 1'b0;
      tick(20);
      frame8(8'hC3);
      chk("post_data", data, 8'hC3);
      chk("post_ctrl", ctrl, 8'h02);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
